// File: rtl/uart_core_if.sv
// uart_core_if: SoC-side byte-stream interface of the console UART.
// slave = UART view, master = SoC view.
interface uart_core_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_busy;
  logic [7:0] rx_data;
  logic       rx_perr;
  logic       rx_ferr;
  logic       rx_valid;
  logic       rx_ready;
  logic       rx_ovr;
  logic       rx_ovr_clr;

  modport slave (
    input  tx_data, tx_valid, rx_ready, rx_ovr_clr,
    output tx_ready, tx_busy, rx_data, rx_perr, rx_ferr, rx_valid, rx_ovr
  );

  modport master (
    output tx_data, tx_valid, rx_ready, rx_ovr_clr,
    input  tx_ready, tx_busy, rx_data, rx_perr, rx_ferr, rx_valid, rx_ovr
  );
endinterface

// File: rtl/uart_core.sv
// uart_core: UART transceiver with DIV-cycle bit timing, optional parity,
// TX FIFO feeding the serialiser and RX FIFO holding {ferr, perr, data}.
module uart_core #(
  parameter int unsigned DIV        = 16,
  parameter int unsigned TX_DEPTH   = 8,
  parameter int unsigned RX_DEPTH   = 8,
  parameter bit          PARITY_EN  = 1'b0,
  parameter bit          PARITY_ODD = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  uart_core_if.slave bus,
  input  logic       rxd,
  output logic       txd
);
  localparam int unsigned CW  = $clog2(DIV);
  localparam int unsigned TAW = $clog2(TX_DEPTH);
  localparam int unsigned RAW = $clog2(RX_DEPTH);
  localparam logic [CW-1:0] BIT_LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(DIV / 2 - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_e;

  // ---------------- TX FIFO ----------------
  logic [7:0]   tx_mem_q [TX_DEPTH];
  logic [TAW:0] tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
  logic         tx_full, tx_empty, tx_push, tx_pop;
  logic [7:0]   tx_head;

  assign tx_full  = (tx_wr_q[TAW] != tx_rd_q[TAW]) &&
                    (tx_wr_q[TAW-1:0] == tx_rd_q[TAW-1:0]);
  assign tx_empty = (tx_wr_q == tx_rd_q);
  assign tx_push  = bus.tx_valid && !tx_full;
  assign tx_head  = tx_mem_q[tx_rd_q[TAW-1:0]];
  assign bus.tx_ready = !tx_full;

  // TX pointer advance
  always_comb begin
    tx_wr_d = tx_push ? tx_wr_q + (TAW+1)'(1) : tx_wr_q;
    tx_rd_d = tx_pop  ? tx_rd_q + (TAW+1)'(1) : tx_rd_q;
  end

  // TX pointer registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_wr_q <= '0;
      tx_rd_q <= '0;
    end else begin
      tx_wr_q <= tx_wr_d;
      tx_rd_q <= tx_rd_d;
    end
  end

  // TX storage write (contents need no reset; pointers define validity)
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem_q[tx_wr_q[TAW-1:0]] <= bus.tx_data;
  end

  // ---------------- TX serialiser ----------------
  state_e        tx_state_q, tx_state_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]    tx_bit_q, tx_bit_d;
  logic [7:0]    tx_sh_q, tx_sh_d;
  logic          tx_par_q, tx_par_d;
  logic          txd_q, txd_d;
  logic          tx_bit_end;

  // TX state register; txd forced high asynchronously by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_q <= S_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_sh_q    <= '0;
      tx_par_q   <= 1'b0;
      txd_q      <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_sh_q    <= tx_sh_d;
      tx_par_q   <= tx_par_d;
      txd_q      <= txd_d;
    end
  end

  // TX next state: bit timing, data shifting, FIFO pop at idle or end of stop
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q + CW'(1);
    tx_bit_d   = tx_bit_q;
    tx_sh_d    = tx_sh_q;
    tx_par_d   = tx_par_q;
    txd_d      = txd_q;
    tx_pop     = 1'b0;
    tx_bit_end = (tx_cnt_q == BIT_LAST);
    if (tx_bit_end) tx_cnt_d = '0;
    unique case (tx_state_q)
      S_IDLE: begin
        tx_cnt_d = '0;
        txd_d    = 1'b1;
        if (!tx_empty) tx_pop = 1'b1;
      end
      S_START: if (tx_bit_end) begin
        tx_state_d = S_DATA;
        tx_bit_d   = '0;
        txd_d      = tx_sh_q[0];
        tx_sh_d    = {1'b0, tx_sh_q[7:1]};
      end
      S_DATA: if (tx_bit_end) begin
        if (tx_bit_q == 3'd7) begin
          tx_state_d = PARITY_EN ? S_PARITY : S_STOP;
          txd_d      = PARITY_EN ? tx_par_q : 1'b1;
        end else begin
          tx_bit_d = tx_bit_q + 3'd1;
          txd_d    = tx_sh_q[0];
          tx_sh_d  = {1'b0, tx_sh_q[7:1]};
        end
      end
      S_PARITY: if (tx_bit_end) begin
        tx_state_d = S_STOP;
        txd_d      = 1'b1;
      end
      S_STOP: if (tx_bit_end) begin
        tx_state_d = S_IDLE;
        txd_d      = 1'b1;
        if (!tx_empty) tx_pop = 1'b1;
      end
      default: tx_state_d = S_IDLE;
    endcase
    // A pop from either IDLE or end-of-STOP launches the next start bit directly.
    if (tx_pop) begin
      tx_state_d = S_START;
      tx_cnt_d   = '0;
      tx_sh_d    = tx_head;
      tx_par_d   = (^tx_head) ^ PARITY_ODD;
      txd_d      = 1'b0;
    end
  end

  assign txd         = txd_q;
  assign bus.tx_busy = !tx_empty || (tx_state_q != S_IDLE);

  // ---------------- RX deserialiser ----------------
  logic rxd_s1_q, rxd_s2_q, rxd_prev_q;

  // Two-flop synchroniser plus one delayed copy for falling-edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxd_s1_q   <= 1'b1;
      rxd_s2_q   <= 1'b1;
      rxd_prev_q <= 1'b1;
    end else begin
      rxd_s1_q   <= rxd;
      rxd_s2_q   <= rxd_s1_q;
      rxd_prev_q <= rxd_s2_q;
    end
  end

  state_e        rx_state_q, rx_state_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]    rx_bit_q, rx_bit_d;
  logic [7:0]    rx_sh_q, rx_sh_d;
  logic          rx_perr_q, rx_perr_d;
  logic          rx_bit_end, rx_push;
  logic [9:0]    rx_word;

  // RX state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state_q <= S_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_sh_q    <= '0;
      rx_perr_q  <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_sh_q    <= rx_sh_d;
      rx_perr_q  <= rx_perr_d;
    end
  end

  // RX next state: half-bit start check, then mid-bit samples every DIV cycles
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q + CW'(1);
    rx_bit_d   = rx_bit_q;
    rx_sh_d    = rx_sh_q;
    rx_perr_d  = rx_perr_q;
    rx_push    = 1'b0;
    rx_bit_end = (rx_cnt_q == BIT_LAST);
    if (rx_bit_end) rx_cnt_d = '0;
    unique case (rx_state_q)
      S_IDLE: begin
        rx_cnt_d = '0;
        if (rxd_prev_q && !rxd_s2_q) begin
          rx_state_d = S_START;
          rx_perr_d  = 1'b0;
        end
      end
      S_START: if (rx_cnt_q == HALF_LAST) begin
        rx_cnt_d   = '0;
        rx_bit_d   = '0;
        rx_state_d = rxd_s2_q ? S_IDLE : S_DATA;
      end
      S_DATA: if (rx_bit_end) begin
        rx_sh_d = {rxd_s2_q, rx_sh_q[7:1]};
        if (rx_bit_q == 3'd7) rx_state_d = PARITY_EN ? S_PARITY : S_STOP;
        else                  rx_bit_d   = rx_bit_q + 3'd1;
      end
      S_PARITY: if (rx_bit_end) begin
        rx_perr_d  = rxd_s2_q ^ (^rx_sh_q) ^ PARITY_ODD;
        rx_state_d = S_STOP;
      end
      S_STOP: if (rx_bit_end) begin
        rx_push    = 1'b1;
        rx_state_d = S_IDLE;
      end
      default: rx_state_d = S_IDLE;
    endcase
  end

  assign rx_word = {~rxd_s2_q, rx_perr_q, rx_sh_q};

  // ---------------- RX FIFO ----------------
  logic [9:0]   rx_mem_q [RX_DEPTH];
  logic [RAW:0] rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
  logic         rx_full, rx_empty, rx_pop, rx_accept;
  logic         rx_ovr_q, rx_ovr_d;

  assign rx_full   = (rx_wr_q[RAW] != rx_rd_q[RAW]) &&
                     (rx_wr_q[RAW-1:0] == rx_rd_q[RAW-1:0]);
  assign rx_empty  = (rx_wr_q == rx_rd_q);
  assign rx_pop    = !rx_empty && bus.rx_ready;
  assign rx_accept = rx_push && (!rx_full || rx_pop);

  // RX pointers and sticky overrun (a new overrun beats a same-cycle clear)
  always_comb begin
    rx_wr_d  = rx_accept ? rx_wr_q + (RAW+1)'(1) : rx_wr_q;
    rx_rd_d  = rx_pop    ? rx_rd_q + (RAW+1)'(1) : rx_rd_q;
    rx_ovr_d = rx_ovr_q;
    if (bus.rx_ovr_clr)        rx_ovr_d = 1'b0;
    if (rx_push && !rx_accept) rx_ovr_d = 1'b1;
  end

  // RX pointer and overrun registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_wr_q  <= '0;
      rx_rd_q  <= '0;
      rx_ovr_q <= 1'b0;
    end else begin
      rx_wr_q  <= rx_wr_d;
      rx_rd_q  <= rx_rd_d;
      rx_ovr_q <= rx_ovr_d;
    end
  end

  // RX storage write
  always_ff @(posedge clk) begin
    if (rx_accept) rx_mem_q[rx_wr_q[RAW-1:0]] <= rx_word;
  end

  // Head is masked while empty so outputs read zero after reset without clearing storage.
  assign {bus.rx_ferr, bus.rx_perr, bus.rx_data} = rx_empty ? '0 : rx_mem_q[rx_rd_q[RAW-1:0]];
  assign bus.rx_valid = !rx_empty;
  assign bus.rx_ovr   = rx_ovr_q;
endmodule

// File: tb/tb_uart_core.sv
// tb_uart_core: checks two UART instances (8N1 and 8E1, DIV=16) with exact
// TX waveform timing, loopback streams of random bytes, a table of injected
// RX frames, false start, overrun and asynchronous reset mid-frame.
module tb_uart_core;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [1:0] tx_valid, rx_ready, rx_ovr_clr, loop, rxd_drv, rxd, txd;
  logic [1:0] tx_ready, tx_busy, rx_valid, rx_perr, rx_ferr, rx_ovr;
  logic [7:0] tx_data [2];
  logic [7:0] rx_data [2];
  logic       txd0, txd1;

  uart_core_if bus0 ();
  uart_core_if bus1 ();

  assign bus0.tx_data = tx_data[0];  assign bus1.tx_data = tx_data[1];
  assign bus0.tx_valid = tx_valid[0]; assign bus1.tx_valid = tx_valid[1];
  assign bus0.rx_ready = rx_ready[0]; assign bus1.rx_ready = rx_ready[1];
  assign bus0.rx_ovr_clr = rx_ovr_clr[0]; assign bus1.rx_ovr_clr = rx_ovr_clr[1];
  assign tx_ready = {bus1.tx_ready, bus0.tx_ready};
  assign tx_busy  = {bus1.tx_busy,  bus0.tx_busy};
  assign rx_valid = {bus1.rx_valid, bus0.rx_valid};
  assign rx_perr  = {bus1.rx_perr,  bus0.rx_perr};
  assign rx_ferr  = {bus1.rx_ferr,  bus0.rx_ferr};
  assign rx_ovr   = {bus1.rx_ovr,   bus0.rx_ovr};
  assign rx_data[0] = bus0.rx_data;
  assign rx_data[1] = bus1.rx_data;
  assign txd = {txd1, txd0};
  assign rxd[0] = loop[0] ? txd0 : rxd_drv[0];
  assign rxd[1] = loop[1] ? txd1 : rxd_drv[1];

  uart_core #(.DIV(16), .TX_DEPTH(8), .RX_DEPTH(8), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) u0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0), .rxd(rxd[0]), .txd(txd0));
  uart_core #(.DIV(16), .TX_DEPTH(8), .RX_DEPTH(8), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) u1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1), .rxd(rxd[1]), .txd(txd1));

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] sent [$];

  typedef struct {
    int         sel;
    logic [7:0] d;
    logic       par;
    logic       stp;
    logic [7:0] ed;
    logic       ep;
    logic       ef;
  } vec_t;
  vec_t tbl [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Push every byte of 'sent' into instance sel with tx_valid held, optionally
  // looped back and drained; bit-level timing derived from frame length only.
  task automatic stream(input int sel, input bit drain);
    int n, f, idx, rcv;
    bit acc;
    n = sent.size(); f = (sel == 1) ? 176 : 160; idx = 0; rcv = 0;
    loop[sel] = 1'b1; rx_ready[sel] = drain;
    tx_valid[sel] = 1'b1; tx_data[sel] = sent[0];
    for (int c = 0; c <= n * f + 30; c++) begin
      acc = tx_valid[sel] && tx_ready[sel];
      tick();
      if (acc) begin
        idx++;
        if (idx < n) tx_data[sel] = sent[idx];
        else tx_valid[sel] = 1'b0;
      end
      if (c == 20) chk("tx_accept_burst", idx, (n < 9) ? n : 9);
      if (n > 9 && c == f) chk("tx_ready_full", tx_ready[sel], 0);
      if (n > 9 && c == f + 1) chk("tx_ready_free", tx_ready[sel], 1);
      if (c == n * f) chk("tx_busy_last", tx_busy[sel], 1);
      if (c == n * f + 1) chk("tx_busy_drop", tx_busy[sel], 0);
      if (drain && rx_valid[sel]) begin
        if (rcv < n) chk("rx_loop_entry", {rx_ferr[sel], rx_perr[sel], rx_data[sel]}, {2'b00, sent[rcv]});
        else chk("rx_loop_extra", rcv + 1, n);
        rcv++;
      end
    end
    if (drain) chk("rx_loop_count", rcv, n);
    tx_valid[sel] = 1'b0; rx_ready[sel] = 1'b0; loop[sel] = 1'b0;
    repeat (4) tick();
  endtask

  // Drive one frame on rxd_drv[sel] with chosen parity and stop bit values.
  task automatic inject(input int sel, input logic [7:0] d, input logic par, input logic stp);
    logic [10:0] fr;
    int nb;
    nb = (sel == 1) ? 11 : 10;
    fr = (sel == 1) ? {stp, par, d, 1'b0} : {1'b0, stp, d, 1'b0};
    for (int b = 0; b < nb; b++) begin
      rxd_drv[sel] = fr[b];
      repeat (16) tick();
    end
    rxd_drv[sel] = 1'b1;
    repeat (24) tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic exp;
    int bad;
    rst_n = 1'b0; tx_valid = '0; rx_ready = '0; rx_ovr_clr = '0; loop = '0; rxd_drv = '1;
    tx_data[0] = '0; tx_data[1] = '0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    tick();

    for (int s = 0; s < 2; s++) begin
      chk("rst_txd", txd[s], 1);
      chk("rst_tx_ready", tx_ready[s], 1);
      chk("rst_tx_busy", tx_busy[s], 0);
      chk("rst_rx_valid", rx_valid[s], 0);
      chk("rst_rx_head", {rx_ferr[s], rx_perr[s], rx_data[s]}, 0);
      chk("rst_rx_ovr", rx_ovr[s], 0);
    end

    // Exact 8N1 waveform for 0x55 pushed at cycle 0
    tx_data[0] = 8'h55; tx_valid[0] = 1'b1;
    tick();
    tx_valid[0] = 1'b0;
    chk("tx_busy_c0", tx_busy[0], 1);
    for (int k = 1; k <= 161; k++) begin
      tick();
      if (k <= 16) exp = 1'b0;
      else if (k <= 144) exp = (8'h55 >> ((k - 17) / 16)) & 8'h01;
      else exp = 1'b1;
      chk("txd_0x55", txd[0], exp);
      if (k == 160) chk("tx_busy_c160", tx_busy[0], 1);
      if (k == 161) chk("tx_busy_c161", tx_busy[0], 0);
    end
    repeat (5) tick();

    // Loopback streams
    sent = '{8'hA5, 8'h3C};
    stream(0, 1'b1);
    sent.delete();
    for (int i = 0; i < 12; i++) sent.push_back(8'($urandom_range(0, 255)));
    stream(0, 1'b1);
    sent.delete();
    for (int i = 0; i < 5; i++) sent.push_back(8'($urandom_range(0, 255)));
    stream(1, 1'b1);

    // False start: low pulse shorter than half a bit
    bad = 0;
    rxd_drv[0] = 1'b0;
    repeat (6) tick();
    rxd_drv[0] = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (rx_valid[0]) bad++;
    end
    chk("false_start_valid_cycles", bad, 0);

    // Injected frame table: fixed corner cases then random ones scored by parity rule
    tbl[0] = '{0, 8'h7E, 1'b0, 1'b0, 8'h7E, 1'b0, 1'b1};
    tbl[1] = '{0, 8'hC3, 1'b0, 1'b1, 8'hC3, 1'b0, 1'b0};
    tbl[2] = '{1, 8'h01, 1'b0, 1'b1, 8'h01, 1'b1, 1'b0};
    tbl[3] = '{1, 8'h01, 1'b1, 1'b1, 8'h01, 1'b0, 1'b0};
    tbl[4] = '{1, 8'hFF, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b0};
    tbl[5] = '{1, 8'h80, 1'b1, 1'b0, 8'h80, 1'b0, 1'b1};
    for (int i = 6; i < 12; i++) begin
      tbl[i].sel = int'($urandom_range(0, 1));
      tbl[i].d   = 8'($urandom_range(0, 255));
      tbl[i].par = 1'($urandom_range(0, 1));
      tbl[i].stp = 1'($urandom_range(0, 1));
      tbl[i].ed  = tbl[i].d;
      tbl[i].ep  = (tbl[i].sel == 1) ? ((tbl[i].par != ^tbl[i].d) ? 1'b1 : 1'b0) : 1'b0;
      tbl[i].ef  = !tbl[i].stp;
    end
    for (int i = 0; i < 12; i++) begin
      inject(tbl[i].sel, tbl[i].d, tbl[i].par, tbl[i].stp);
      chk("inj_valid", rx_valid[tbl[i].sel], 1);
      chk("inj_data", rx_data[tbl[i].sel], tbl[i].ed);
      chk("inj_perr", rx_perr[tbl[i].sel], tbl[i].ep);
      chk("inj_ferr", rx_ferr[tbl[i].sel], tbl[i].ef);
      rx_ready[tbl[i].sel] = 1'b1;
      tick();
      rx_ready[tbl[i].sel] = 1'b0;
      chk("inj_popped", rx_valid[tbl[i].sel], 0);
    end

    // Overrun: nine frames into an eight-deep RX FIFO with no pops
    sent.delete();
    for (int i = 0; i < 9; i++) sent.push_back(8'($urandom_range(0, 255)));
    stream(0, 1'b0);
    chk("ovr_set", rx_ovr[0], 1);
    for (int i = 0; i < 8; i++) begin
      chk("ovr_valid", rx_valid[0], 1);
      chk("ovr_entry", {rx_ferr[0], rx_perr[0], rx_data[0]}, {2'b00, sent[i]});
      rx_ready[0] = 1'b1;
      tick();
      rx_ready[0] = 1'b0;
    end
    chk("ovr_drained", rx_valid[0], 0);
    chk("ovr_still_set", rx_ovr[0], 1);
    rx_ovr_clr[0] = 1'b1;
    tick();
    rx_ovr_clr[0] = 1'b0;
    chk("ovr_cleared", rx_ovr[0], 0);

    // Asynchronous reset in the middle of a frame with more bytes queued
    tx_data[0] = 8'h00; tx_valid[0] = 1'b1;
    repeat (3) tick();
    tx_valid[0] = 1'b0;
    repeat (40) tick();
    chk("mid_frame_txd_low", txd[0], 0);
    #3 rst_n = 1'b0;
    #1;
    chk("rst_async_txd", txd[0], 1);
    chk("rst_async_busy", tx_busy[0], 0);
    chk("rst_async_ready", tx_ready[0], 1);
    #10 rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (txd[0] !== 1'b1 || tx_busy[0] !== 1'b0 || rx_valid[0] !== 1'b0) bad++;
    end
    chk("post_reset_quiet_cycles", bad, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
